// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status codes, fetch sequencer state encoding, reset PC.
// Pure declarations; no timing or flow-control behaviour.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    typedef enum logic [1:0] {
        SEQ_RUN      = 2'd0,
        SEQ_RET_WAIT = 2'd1,
        SEQ_HALT     = 2'd2,
        SEQ_ERROR    = 2'd3
    } seq_state_e;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'd32;

endpackage

// File: rtl/instr_len_decode.sv
// Maps an icode to its byte length, validity and whether valC is the branch/call target.
// Purely combinational, zero latency, no flow control.
module instr_len_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic [3:0] o_len,
    output logic       o_valid,
    output logic       o_uses_valc
);

    always_comb begin
        o_len       = 4'd0;
        o_valid     = 1'b1;
        o_uses_valc = (i_icode == IJXX) || (i_icode == ICALL);
        case (i_icode)
            IHALT, INOP, IRET:                o_len = 4'd1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:     o_len = 4'd2;
            IJXX, ICALL:                      o_len = 4'd9;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:        o_len = 4'd10;
            default: begin
                o_len   = 4'd0;
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Y86-64 PC owner: picks fetch PC (mispredict > ret > predicted), bubbles during ret, freezes on halt/error.
// f_pc/f_bubble/f_stat are combinational; state advances one cycle later; stall_f holds PC unless redirected.
module fetch_sequencer
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [63:0] IMEM_FIRST = 64'd1,
    parameter logic [63:0] IMEM_LAST  = 64'd100,
    parameter int          CNT_W      = 32
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        f_icode,
    input  logic [63:0]       f_valC,
    input  logic [63:0]       f_valP,
    input  logic              stall_f,
    input  logic              m_mispredict,
    input  logic [63:0]       m_valA,
    input  logic              w_ret,
    input  logic [63:0]       w_valM,
    output logic [63:0]       f_pc,
    output logic              f_bubble,
    output logic [2:0]        f_stat,
    output logic [1:0]        seq_state,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_e        r_state;
    seq_state_e        w_next_state;
    logic [63:0]       r_pred_pc;
    logic [CNT_W-1:0]  r_count;
    stat_e             r_term_stat;

    logic [3:0]        w_len;
    logic              w_valid;
    logic              w_uses_valc;
    logic [63:0]       w_len64;
    logic [64:0]       w_end;
    logic              w_adr;
    stat_e             w_stat;
    logic              w_accept;
    logic              w_ok;

    instr_len_decode u_len (
        .i_icode     (f_icode),
        .o_len       (w_len),
        .o_valid     (w_valid),
        .o_uses_valc (w_uses_valc)
    );

    assign f_pc = m_mispredict                             ? m_valA :
                  (w_ret && (r_state == SEQ_RET_WAIT))     ? w_valM :
                                                             r_pred_pc;

    // Invalid icodes are range-checked as one byte so ADR can still outrank INS.
    assign w_len64 = {60'd0, (w_valid ? w_len : 4'd1)};
    assign w_end   = {1'b0, f_pc} + {1'b0, w_len64} - 65'd1;
    assign w_adr   = (f_pc < IMEM_FIRST) || w_end[64] || (w_end[63:0] > IMEM_LAST);

    always_comb begin
        w_stat = STAT_AOK;
        if (w_adr)                 w_stat = STAT_ADR;
        else if (!w_valid)         w_stat = STAT_INS;
        else if (f_icode == IHALT) w_stat = STAT_HLT;
    end

    assign w_ok     = (w_stat == STAT_AOK) || (w_stat == STAT_HLT);
    assign w_accept = !f_bubble && (!stall_f || m_mispredict);

    always_ff @(posedge clk) begin
        if (reset) r_state <= SEQ_RUN;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            if (!w_ok)                   w_next_state = SEQ_ERROR;
            else if (w_stat == STAT_HLT) w_next_state = SEQ_HALT;
            else if (f_icode == IRET)    w_next_state = SEQ_RET_WAIT;
            else                         w_next_state = SEQ_RUN;
        end
    end

    always_comb begin
        f_bubble = 1'b0;
        f_stat   = w_stat;
        case (r_state)
            SEQ_RUN:      f_bubble = 1'b0;
            SEQ_RET_WAIT: f_bubble = !(w_ret || m_mispredict);
            default: begin
                f_bubble = !m_mispredict;
                if (!m_mispredict) f_stat = r_term_stat;
            end
        endcase
        if (reset) begin
            f_bubble = 1'b1;
            f_stat   = STAT_AOK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_pc   <= RESET_PC;
            r_count     <= '0;
            r_term_stat <= STAT_AOK;
        end else if (w_accept) begin
            r_term_stat <= w_stat;
            if (w_ok) begin
                if (r_count != '1) r_count <= r_count + CNT_ONE;
                if (f_icode != IRET) r_pred_pc <= w_uses_valc ? f_valC : f_valP;
            end
        end
    end

    assign seq_state   = r_state;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed walk through the fetch scenarios followed by randomized traffic against a behavioural model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  f_icode;
    logic [63:0] f_valC, f_valP, m_valA, w_valM;
    logic        stall_f, m_mispredict, w_ret;
    logic [63:0] f_pc;
    logic        f_bubble;
    logic [2:0]  f_stat;
    logic [1:0]  seq_state;
    logic [3:0]  fetch_count;

    fetch_sequencer #(.CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .f_icode      (f_icode),
        .f_valC       (f_valC),
        .f_valP       (f_valP),
        .stall_f      (stall_f),
        .m_mispredict (m_mispredict),
        .m_valA       (m_valA),
        .w_ret        (w_ret),
        .w_valM       (w_valM),
        .f_pc         (f_pc),
        .f_bubble     (f_bubble),
        .f_stat       (f_stat),
        .seq_state    (seq_state),
        .fetch_count  (fetch_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: mode 0 running, 1 waiting for ret, 2 halted, 3 errored.
    int          len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};
    int          m_mode = 0;
    logic [63:0] m_pc   = 64'd0;
    int          m_cnt  = 0;
    int          m_term = 1;
    bit          model_live = 0;
    logic [63:0] e_pc;
    bit          e_bub;
    int          e_st;
    int          e_stat;

    task automatic idle();
        reset = 1'b0; f_icode = 4'h1; f_valC = 64'd0; f_valP = 64'd0;
        stall_f = 1'b0; m_mispredict = 1'b0; m_valA = 64'd0; w_ret = 1'b0; w_valM = 64'd0;
    endtask

    task automatic sample();
        int L;
        bit ins, adr;
        #1;
        if (m_mispredict)             e_pc = m_valA;
        else if (w_ret && m_mode == 1) e_pc = w_valM;
        else                           e_pc = m_pc;
        L = len_tab[f_icode];
        ins = (L == 0);
        if (ins) L = 1;
        adr = (e_pc == 64'd0) || (e_pc > (64'hFFFF_FFFF_FFFF_FFFF - 64'(L - 1)))
              || ((e_pc + 64'(L - 1)) > 64'd100);
        e_st = adr ? 3 : ins ? 4 : (f_icode == 4'h0) ? 2 : 1;
        if (reset)            e_bub = 1;
        else if (m_mode == 0) e_bub = 0;
        else if (m_mode == 1) e_bub = !(w_ret || m_mispredict);
        else                  e_bub = !m_mispredict;
        e_stat = reset ? 1 : ((m_mode >= 2 && !m_mispredict) ? m_term : e_st);
        chk("f_bubble", 64'(f_bubble), 64'(e_bub));
        chk("f_stat", 64'(f_stat), 64'(e_stat));
        if (model_live) begin
            chk("f_pc", f_pc, e_pc);
            chk("seq_state", 64'(seq_state), 64'(m_mode));
            chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            m_pc = 64'd32; m_mode = 0; m_cnt = 0; model_live = 1;
        end else if (!e_bub && (!stall_f || m_mispredict)) begin
            if (e_st >= 3) begin
                m_mode = 3; m_term = e_st;
            end else begin
                if (m_cnt < 15) m_cnt++;
                if (f_icode == 4'h9) m_mode = 1;
                else begin
                    m_pc = (f_icode == 4'h7 || f_icode == 4'h8) ? f_valC : f_valP;
                    if (f_icode == 4'h0) begin m_mode = 2; m_term = 2; end
                    else m_mode = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        sample(); advance();
        sample(); chk("reset_pc", f_pc, 64'd32); chk("reset_cnt", 64'(fetch_count), 64'd0); advance();

        idle(); f_icode = 4'h3; f_valP = 64'd42;
        sample(); chk("pc_irmovq", f_pc, 64'd32); advance();
        idle(); f_icode = 4'h6; f_valP = 64'd44;
        sample(); chk("pc_subq", f_pc, 64'd42); advance();
        idle(); f_icode = 4'h1; f_valP = 64'd45;
        sample(); chk("pc_44", f_pc, 64'd44); chk("cnt_two", 64'(fetch_count), 64'd2);
        chk("stat_aok", 64'(f_stat), 64'd1); advance();
        idle(); m_mispredict = 1'b1; m_valA = 64'd40; f_icode = 4'h7; f_valC = 64'd70; f_valP = 64'd49;
        sample(); chk("pc_jxx", f_pc, 64'd40); advance();
        idle(); stall_f = 1'b1; f_valP = 64'd71;
        sample(); chk("pc_target", f_pc, 64'd70); advance();
        idle(); m_mispredict = 1'b1; m_valA = 64'd49; f_icode = 4'h6; f_valP = 64'd51;
        sample(); chk("pc_mispredict", f_pc, 64'd49); advance();
        idle(); f_valP = 64'd52;
        sample(); chk("pc_after_redir", f_pc, 64'd51); advance();

        idle(); m_mispredict = 1'b1; m_valA = 64'd50; f_icode = 4'h9; f_valP = 64'd51;
        sample(); chk("pc_ret", f_pc, 64'd50); advance();
        for (int i = 0; i < 3; i++) begin
            idle();
            sample(); chk("ret_bubble", 64'(f_bubble), 64'd1); chk("ret_state", 64'(seq_state), 64'd1); advance();
        end
        idle(); w_ret = 1'b1; w_valM = 64'd60; f_valP = 64'd61;
        sample(); chk("pc_ret_target", f_pc, 64'd60); chk("ret_resume", 64'(f_bubble), 64'd0); advance();

        idle(); stall_f = 1'b1; f_valP = 64'd62;
        sample(); chk("run_after_ret", 64'(seq_state), 64'd0); chk("pc_stall", f_pc, 64'd61); advance();
        idle(); stall_f = 1'b1; m_mispredict = 1'b1; m_valA = 64'd80; f_valP = 64'd81;
        sample(); chk("pc_stall_redir", f_pc, 64'd80); advance();
        idle(); f_valP = 64'd82;
        sample(); chk("pc_post_stall", f_pc, 64'd81); advance();

        idle(); m_mispredict = 1'b1; m_valA = 64'd33; f_icode = 4'hC;
        sample(); chk("stat_ins", 64'(f_stat), 64'd4); advance();
        for (int i = 0; i < 2; i++) begin
            idle();
            sample(); chk("err_state", 64'(seq_state), 64'd3); chk("err_bubble", 64'(f_bubble), 64'd1);
            chk("err_stat", 64'(f_stat), 64'd4); advance();
        end
        idle(); m_mispredict = 1'b1; m_valA = 64'd95; f_icode = 4'h3; f_valP = 64'd105;
        sample(); chk("stat_adr", 64'(f_stat), 64'd3); advance();
        idle();
        sample(); chk("adr_state", 64'(seq_state), 64'd3); chk("adr_hold", 64'(f_stat), 64'd3); advance();

        idle(); m_mispredict = 1'b1; m_valA = 64'd20; f_icode = 4'h0; f_valP = 64'd21;
        sample(); chk("stat_hlt", 64'(f_stat), 64'd2); advance();
        idle();
        sample(); chk("halt_state", 64'(seq_state), 64'd2); chk("halt_stat", 64'(f_stat), 64'd2);
        chk("halt_bubble", 64'(f_bubble), 64'd1); advance();
        idle(); reset = 1'b1;
        sample(); advance();
        idle();
        sample(); chk("rst_pc", f_pc, 64'd32); chk("rst_cnt", 64'(fetch_count), 64'd0);
        chk("rst_state", 64'(seq_state), 64'd0); advance();

        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom % 64) == 0;
            m_mispredict = ($urandom % 8) == 0;
            stall_f      = ($urandom % 4) == 0;
            w_ret        = ($urandom % 3) == 0;
            f_icode      = (($urandom % 5) == 0) ? 4'($urandom % 16) : 4'($urandom % 12);
            case ($urandom % 8)
                0:       m_valA = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16);
                1:       m_valA = 64'd0;
                default: m_valA = 64'($urandom % 110);
            endcase
            w_valM = 64'($urandom % 110);
            f_valC = 64'($urandom % 110);
            f_valP = 64'($urandom % 110);
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter for the pipelined Y86-64 core and sequences the combinational fetch stage.
- Each cycle it selects the fetch PC from three sources:
  - M-stage mispredict redirect
  - W-stage ret resolution
  - its own predicted-PC register
- It inserts fetch bubbles while a ret is unresolved, freezes on halt or fetch error, and produces the F-stage status code.

Parameters:
- RESET_PC, 32, first PC after reset; program image starts at byte 32.
- IMEM_FIRST, 1, lowest valid instruction-memory byte address.
- IMEM_LAST, 100, highest valid instruction-memory byte address.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- f_icode  in  4  icode decoded by fetch at f_pc.
- f_valC  in  64  constant field decoded by fetch at f_pc.
- f_valP  in  64  fall-through address from fetch at f_pc.
- stall_f  in  1  hold request from pipeline hazard control.
- m_mispredict  in  1  M-stage jXX not taken; redirect required.
- m_valA  in  64  correct fall-through PC for mispredict.
- w_ret  in  1  ret in W stage this cycle.
- w_valM  in  64  return address read by that ret.
- f_pc  out  64  PC presented to fetch (combinational).
- f_bubble  out  1  force a nop into the D register this cycle.
- f_stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- seq_state  out  2  0=RUN, 1=RET_WAIT, 2=HALT, 3=ERROR.
- fetch_count  out  CNT_W  number of non-bubble instructions accepted; saturates at all-ones.

Behaviour:
- Reset (synchronous, reset=1 at rising edge):
  - pred_pc <= RESET_PC, seq_state <= RUN, fetch_count <= 0.
  - During the reset cycle: f_bubble=1, f_stat=AOK.
  - Reset overrides every other input, including reset asserted mid-RET_WAIT, HALT or ERROR.
- f_pc select, in priority order:
  - m_mispredict → m_valA
  - else w_ret in RET_WAIT → w_valM
  - else pred_pc
- Instruction length from f_icode:
  - 0, 1, 9 → 1 byte
  - 2, 6, A, B → 2 bytes
  - 7, 8 → 9 bytes
  - 3, 4, 5 → 10 bytes
  - C–F → invalid
- Length arithmetic is 64-bit. ADR error if f_pc < IMEM_FIRST, or f_pc + len − 1 > IMEM_LAST, or that sum wraps past 2^64.
- f_stat, evaluated on the selected f_pc: ADR takes precedence over INS, INS over HLT, otherwise AOK.
- Predicted next PC: f_valC for icode 7 or 8, else f_valP.
- Accept condition: a cycle where f_bubble=0 and (stall_f=0 or m_mispredict=1).
- RUN:
  - stall_f=1 and no redirect: hold pred_pc, no state change, no count.
  - Accept with AOK:
    - pred_pc <= predicted next PC; fetch_count += 1.
    - icode 9 → RET_WAIT, pred_pc held.
    - icode 0 → HALT.
  - Accept with ADR or INS: → ERROR, pred_pc held.
- RET_WAIT:
  - f_bubble=1 every cycle until w_ret=1.
  - On w_ret: f_bubble=0 and fetch proceeds at w_valM using the RUN rules (a ret at the target re-enters RET_WAIT).
- HALT / ERROR:
  - f_bubble=1; f_stat holds the terminating code; pred_pc frozen.
  - Only reset or m_mispredict leave these states, since the halt or error may have been fetched on the wrong path.
- m_mispredict in any non-reset state:
  - Wins over stall_f and w_ret.
  - Fetch proceeds at m_valA; the RUN transition rules apply to the redirected instruction.
- fetch_count: no increment on bubble or stall cycles; at saturation it holds.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants IHALT..IPOPQ
  - stat codes AOK/HLT/ADR/INS
  - seq_state encoding
  - RESET_PC default
- Sub-module instr_len_decode (combinational): f_icode → length[3:0], valid, uses_valC_as_target. Reused later by the decode-stage checker.

Test Plan:
- Reset, then no stalls: irmovq at 32 (len 10) then subq at 42 (len 2) → f_pc 32, 42, 44; fetch_count=2 after two accepts; f_stat=AOK.
- jXX at 40, valC=70 → next f_pc=70. Then assert m_mispredict with m_valA=49 → f_pc=49 that same cycle, and pred_pc follows from 49.
- ret fetched at 50 → seq_state=RET_WAIT, f_bubble=1 for 3 cycles. Then w_ret=1 with w_valM=60 → f_pc=60, f_bubble=0, state RUN.
- stall_f=1 for 2 cycles with m_mispredict asserted on the second → pc held on the first cycle, redirect taken on the second.
- Errors:
  - f_icode=0xC at 33 → f_stat=INS, state ERROR, f_bubble=1 on the following cycles.
  - Separately, irmovq at 95 → f_stat=ADR, since 95+9 > 100.
- halt fetched → state HALT, f_stat=HLT. Then reset asserted mid-HALT → next cycle f_pc=32, fetch_count=0, state RUN.
